// File: rtl/moore_pattern_detector.sv
// -----------------------------------------------------------------------------
// moore_pattern_detector
//
// Serial pattern detector with a Moore-style match output. A pattern of up to
// MAX_LEN bits is loaded together with its effective length and an overlap
// mode. Serial data then shifts into a history register, and the FSM enters
// HIT for one cycle each time the newest L bits equal the loaded pattern.
//
// Build option:
//   MATCH_CNT_EN  - when defined, a saturating CNT_W-bit match counter with a
//                   synchronous clear is built and its low six bits appear on
//                   uo_out[7:2]. When undefined, no counter exists, ui_in[6]
//                   is ignored and uo_out[7:2] reads 0. The FSM is identical
//                   in both builds.
//
// Parameters:
//   MAX_LEN  maximum pattern length in bits (2..8)
//   CNT_W    match counter width (6..16)
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   ena      enable; when low every register holds its value
//   ui_in    [0] serial data x, [1] load strobe, [4:2] length-1,
//            [5] overlap mode, [6] counter clear, [7] unused
//   uio_in   pattern bits, sampled on load (bit L-1 is expected first)
//   uo_out   [0] match, [1] armed, [7:2] match count[5:0]
//   uio_out  constant 0
//   uio_oe   constant 0 (all uio pins are inputs)
// -----------------------------------------------------------------------------
module moore_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_UNLOADED = 2'd0,
    ST_RUN      = 2'd1,
    ST_HIT      = 2'd2
  } state_t;

  localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);

  // Compare the low len bits of the history against the pattern; bits at or
  // above len are don't-care.
  function automatic logic pattern_eq(
    input logic [MAX_LEN-1:0] hist,
    input logic [MAX_LEN-1:0] pat,
    input logic [3:0]         len
  );
    logic [MAX_LEN-1:0] mask;
    mask = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    pattern_eq = (((hist ^ pat) & mask) == {MAX_LEN{1'b0}});
  endfunction

  // Registered state
  state_t             state_r;
  logic [MAX_LEN-1:0] pattern_r;
  logic [3:0]         len_r;
  logic               overlap_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [3:0]         fill_r;
  logic               match_r;
  logic               armed_r;

  // Decoded inputs and next-value helpers
  logic               x_s;
  logic               load_s;
  logic               clr_s;
  logic [3:0]         len_sel_s;
  logic [MAX_LEN-1:0] hist_shift_s;
  logic [4:0]         fill_p1_s;
  logic               fill_ok_s;
  logic [3:0]         fill_inc_s;
  logic               hit_s;
  logic [5:0]         cnt_view_s;

  assign x_s    = ui_in[0];
  assign load_s = ui_in[1];
  assign clr_s  = ui_in[6];

  // Effective length for a load: encoded length + 1, clamped to MAX_LEN.
  always_comb begin
    len_sel_s = {1'b0, ui_in[4:2]} + 4'd1;
    if (len_sel_s > MAX_LEN_W) begin
      len_sel_s = MAX_LEN_W;
    end else begin
      len_sel_s = {1'b0, ui_in[4:2]} + 4'd1;
    end
  end

  // Hit detection for the current cycle, including the bit being sampled now.
  always_comb begin
    hist_shift_s = {hist_r[MAX_LEN-2:0], x_s};
    fill_p1_s    = {1'b0, fill_r} + 5'd1;
    fill_ok_s    = (fill_p1_s >= {1'b0, len_r});
    if (fill_r == MAX_LEN_W) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + 4'd1;
    end
    // A load cycle never produces a hit, and nothing is armed before a load.
    hit_s = (state_r != ST_UNLOADED) && !load_s && fill_ok_s &&
            pattern_eq(hist_shift_s, pattern_r, len_r);
  end

  // Detector FSM with registered match/armed flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_UNLOADED;
      pattern_r <= {MAX_LEN{1'b0}};
      len_r     <= 4'd0;
      overlap_r <= 1'b0;
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= 4'd0;
      match_r   <= 1'b0;
      armed_r   <= 1'b0;
    end else if (ena) begin
      if (load_s) begin
        // The x bit of the load cycle is discarded.
        state_r   <= ST_RUN;
        pattern_r <= uio_in[MAX_LEN-1:0];
        len_r     <= len_sel_s;
        overlap_r <= ui_in[5];
        hist_r    <= {MAX_LEN{1'b0}};
        fill_r    <= 4'd0;
        match_r   <= 1'b0;
        armed_r   <= 1'b1;
      end else if (state_r == ST_UNLOADED) begin
        state_r <= ST_UNLOADED;
        match_r <= 1'b0;
        armed_r <= 1'b0;
      end else begin
        hist_r  <= hist_shift_s;
        armed_r <= 1'b1;
        if (hit_s) begin
          state_r <= ST_HIT;
          match_r <= 1'b1;
          // Non-overlap: the next detection has to be built from fresh bits.
          fill_r  <= overlap_r ? fill_inc_s : 4'd0;
        end else begin
          state_r <= ST_RUN;
          match_r <= 1'b0;
          fill_r  <= fill_inc_s;
        end
      end
    end
  end

`ifdef MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic             unused_s;

  // Saturating match counter; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (ena) begin
      if (clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (hit_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign cnt_view_s = cnt_r[5:0];
  assign unused_s   = ^{ui_in[7], uio_in};
`else
  logic unused_s;

  assign cnt_view_s = 6'd0;
  assign unused_s   = ^{ui_in[7], clr_s, uio_in};
`endif

  assign uo_out  = {cnt_view_s, armed_r, match_r};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_moore_pattern_detector
//
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (counter saturation, clear vs hit, asynchronous reset), then
// random stimulus compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_moore_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_total;
  int n_pass;

  moore_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_loaded;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];     // bits received since load / last non-overlap hit
  bit         m_match;
  int         m_cnt;

  function automatic void model_reset();
    m_loaded = 1'b0;
    m_pat    = 8'h00;
    m_len    = 0;
    m_ovl    = 1'b0;
    m_q.delete();
    m_match  = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic void model_edge(input bit e, input bit [7:0] ui, input bit [7:0] uio);
    bit hit;
    hit = 1'b0;
    if (e) begin
      if (ui[1]) begin
        m_loaded = 1'b1;
        m_pat    = uio;
        m_len    = (int'(ui[4:2]) + 1 > MAX_LEN) ? MAX_LEN : int'(ui[4:2]) + 1;
        m_ovl    = ui[5];
        m_q.delete();
      end else if (m_loaded) begin
        m_q.push_back(ui[0]);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1'b1;
          // k = 0 is the newest bit and must equal pattern bit 0
          for (int k = 0; k < m_len; k++) begin
            if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          end
        end
        if (hit && !m_ovl) m_q.delete();
      end
      m_match = hit;
      if (ui[6]) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [7:0] exp_uo(input bit m, input bit a, input int c);
    logic [7:0] e;
    e[0] = m;
    e[1] = a;
`ifdef MATCH_CNT_EN
    e[7:2] = c[5:0];
`else
    e[7:2] = 6'd0;
`endif
    return e;
  endfunction

  function automatic logic [7:0] model_uo();
    return exp_uo(m_match, m_loaded, m_cnt);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
  endtask

  // Apply one cycle of inputs, advance past the edge, update the model.
  task automatic step(input bit e, input bit [7:0] ui, input bit [7:0] uio);
    ena    = e;
    ui_in  = ui;
    uio_in = uio;
    @(posedge clk);
    #1;
    model_edge(e, ui, uio);
  endtask

  typedef struct {
    bit       en;
    bit [7:0] ui;
    bit [7:0] uio;
    bit       m;
    bit       a;
    int       c;
  } vec_t;

  vec_t vecs[22];

  initial begin
    n_total = 0;
    n_pass  = 0;

    // ui: [0]=x [1]=load [4:2]=len-1 [5]=overlap [6]=clear
    // "110" len=3 overlap, stream 1,1,0,0
    vecs[0]  = '{1'b1, 8'h2A, 8'h06, 1'b0, 1'b1, 0};
    vecs[1]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 0};
    vecs[2]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 0};
    vecs[3]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1};
    vecs[4]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1};
    // "11" len=2 overlap (load with clear), stream 1,1,1,1
    vecs[5]  = '{1'b1, 8'h66, 8'h03, 1'b0, 1'b1, 0};
    vecs[6]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 0};
    vecs[7]  = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1};
    vecs[8]  = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 2};
    vecs[9]  = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 3};
    // "11" len=2 non-overlap, stream 1,1,1,1
    vecs[10] = '{1'b1, 8'h46, 8'h03, 1'b0, 1'b1, 0};
    vecs[11] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 0};
    vecs[12] = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1};
    vecs[13] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1};
    vecs[14] = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 2};
    // partial "110", then reload "1" len=1 with x=1 in the load cycle
    vecs[15] = '{1'b1, 8'h0A, 8'h06, 1'b0, 1'b1, 2};
    vecs[16] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 2};
    vecs[17] = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 2};
    vecs[18] = '{1'b1, 8'h03, 8'h01, 1'b0, 1'b1, 2};
    vecs[19] = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 3};
    // ena low holds HIT and count; then a mismatching bit
    vecs[20] = '{1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 3};
    vecs[21] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 3};

    // ---- reset state ----
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #12;
    check("reset_uo_out", uo_out, 8'h00);
    check("uio_out_zero", uio_out, 8'h00);
    check("uio_oe_zero", uio_oe, 8'h00);
    rst_n = 1'b1;

    // ---- unloaded ignores x ----
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h01, 8'hFF);
      check("unloaded_idle", uo_out, 8'h00);
    end

    // ---- directed table ----
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].en, vecs[i].ui, vecs[i].uio);
      check($sformatf("table_%0d", i), uo_out, exp_uo(vecs[i].m, vecs[i].a, vecs[i].c));
    end

    // ---- counter saturation: "1" len=1 overlap, 70 hits ----
    step(1'b1, 8'h62, 8'h01);   // load with clear
    check("sat_load", uo_out, model_uo());
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 8'h01, 8'h00);
      if (i % 10 == 9) check($sformatf("sat_run_%0d", i), uo_out, model_uo());
    end
    check("sat_final", uo_out, exp_uo(1'b1, 1'b1, CNT_MAX));

    // ---- clear in the same cycle as a hit ----
    step(1'b1, 8'h41, 8'h00);
    check("clear_vs_hit", uo_out, exp_uo(1'b1, 1'b1, 0));

    // ---- async reset while in HIT, between edges ----
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", uo_out, 8'h00);
    model_reset();
    #2;
    rst_n = 1'b1;
    step(1'b1, 8'h01, 8'h06);
    check("post_reset_1", uo_out, 8'h00);
    step(1'b1, 8'h01, 8'h06);
    check("post_reset_2", uo_out, 8'h00);
    step(1'b1, 8'h00, 8'h06);
    check("post_reset_3", uo_out, 8'h00);

    // ---- random stimulus vs model ----
    for (int i = 0; i < 600; i++) begin
      bit       e;
      bit [7:0] ui;
      bit [2:0] lf;
      e  = ($urandom % 8) != 0;
      lf = (($urandom % 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      ui = 8'($urandom);
      ui[1]   = (i == 0) || (($urandom % 14) == 0);
      ui[4:2] = lf;
      ui[6]   = ($urandom % 40) == 0;
      step(e, ui, 8'($urandom));
      check($sformatf("rand_%0d", i), uo_out, model_uo());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/moore_pattern_detector.md
MOORE_PATTERN_DETECTOR -- requirements
Module: moore_pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits; legal range 2..8.
REQ-002 Parameter CNT_W, default 8, match-counter width; legal range 6..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  enable; when low, all registers SHALL hold their values.
REQ-006 ui_in  input  8  [0] serial data x; [1] load strobe; [4:2] pattern length-1; [5] overlap mode; [6] counter clear; [7] unused.
REQ-007 uio_in  input  8  pattern bits, sampled on load; bit len-1 is the first bit expected, bit 0 the last.
REQ-008 uo_out  output  8  [0] match (Moore); [1] armed; [7:2] match count[5:0].
REQ-009 uio_out  output  8  SHALL be constant 0.
REQ-010 uio_oe  output  8  SHALL be constant 0 (all uio pins are inputs).

Function
REQ-011 FSM states: UNLOADED, RUN, HIT; armed = (state != UNLOADED); match = (state == HIT), decoded from registered state only.
REQ-012 Effective length L = min(ui_in[4:2]+1, MAX_LEN), latched with the pattern on load; an encoding of 0 gives L = 1.
REQ-013 Load (ena=1, ui_in[1]=1): pattern, L and mode latched; history and fill count cleared; next state RUN; the x bit of the load cycle is discarded.
REQ-014 In RUN/HIT with no load: x shifts into history (newest at bit 0); fill count increments, saturating at MAX_LEN.
REQ-015 Next state is HIT when fill+1 >= L and the L newest bits, including the current x, equal pattern[L-1:0]; otherwise it is RUN.
REQ-016 Latency: match SHALL be high in the cycle immediately after the edge that samples the final pattern bit, for exactly one cycle per detection.
REQ-017 Overlap mode (ui_in[5]=1 at load): history is retained after a hit, so back-to-back HIT cycles are allowed.
REQ-018 Non-overlap mode: on entry to HIT the fill count resets to 0, so the next detection needs L fresh bits.
REQ-019 In UNLOADED, x is ignored and no match occurs.
REQ-020 The counter increments on each transition into or within HIT and saturates at 2^CNT_W-1.
REQ-021 Clear (ui_in[6]=1) zeroes the counter and wins over a simultaneous increment.
REQ-022 Load during RUN/HIT replaces the pattern, suppresses any match for that cycle and leaves the counter unchanged.

Reset
REQ-023 On rst_n low, immediately and independently of clk: state UNLOADED; pattern, L, mode, history, fill and counter all 0; uo_out = 8'h00.
REQ-024 Reset asserted mid-sequence SHALL abandon any partial match; after release the block SHALL require a new load.

Configuration
REQ-025 Macro MATCH_CNT_EN.
- Defined: the counter and clear of REQ-020/021 are present, and uo_out[7:2] = count[5:0].
- Undefined: no counter registers exist, ui_in[6] is ignored, and uo_out[7:2] = 0.
- Both builds: FSM behaviour is identical.

Verification
REQ-026 Load uio_in=8'h06, len=2, overlap=1; stream x=1,1,0 -> match high only in the cycle after the 0 is sampled; count=1.
REQ-027 Load 8'h03, len=1, overlap=1; stream 1,1,1,1 -> match in the cycles after bits 2, 3 and 4; count=3. Same stream with overlap=0 -> matches after bits 2 and 4 only; count=2.
REQ-028 Load during a partial match (two bits of "110" received), with new pattern 8'h01 and len=0; then x=1 -> no match in the load cycle; match on the following cycle.
REQ-029 Run with MATCH_CNT_EN and CNT_W=6, 70 hits -> uo_out[7:2]=6'h3F (saturated); assert clear in the same cycle as a hit -> count=0.
REQ-030 Assert rst_n=0 between clock edges while in HIT -> uo_out=8'h00 with no clock edge; after release, x stream 1,1,0 -> no match until a new load.
